// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one single-port data memory between the vcore data port
//            and a secondary DMA/debug requester. Whole transfers are granted;
//            the core has priority, and a saturating streak counter forces a
//            DMA grant after MAX_CORE_BURST consecutive core grants made while
//            DMA was waiting. Arbitration in IDLE is combinational, so an
//            uncontended request reaches the memory in the same cycle.
// Ports    : clk, reset_n (async, active-low)
//            core_*  : core request (level until core_valid_o), rdata/valid
//            dma_*   : DMA request  (level until dma_ack_o),   rdata/ack
//            mem_*   : memory side; req held with stable we/addr/wdata
//                      until mem_ack_i, rdata valid with mem_ack_i
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MAX_CORE_BURST = 4,
    parameter int AW             = 16,
    parameter int DW             = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          core_enable_i,
    input  logic          core_write_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    output logic [DW-1:0] core_rdata_o,
    output logic          core_valid_o,
    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [DW-1:0] dma_wdata_i,
    output logic [DW-1:0] dma_rdata_o,
    output logic          dma_ack_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam logic [3:0] c_max_streak = 4'(MAX_CORE_BURST);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_CORE = 2'd1,
        BUSY_DMA  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_streak;
    logic [3:0] w_streak_next;
    logic       w_own_core;
    logic       w_own_dma;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_streak <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_streak <= w_streak_next;
        end
    end

    // Next state, streak update and current owner. In IDLE the owner is the
    // result of same-cycle arbitration; in BUSY_x it is the latched owner and
    // the other requester is ignored until mem_ack_i.
    always_comb begin
        w_state_next  = r_state;
        w_streak_next = r_streak;
        w_own_core    = 1'b0;
        w_own_dma     = 1'b0;
        case (r_state)
            IDLE: begin
                if (core_enable_i && (!dma_req_i || (r_streak < c_max_streak))) begin
                    w_own_core = 1'b1;
                    // Only reachable with streak below the limit when DMA
                    // waits, so the increment cannot overshoot.
                    w_streak_next = dma_req_i ? (r_streak + 4'd1) : 4'd0;
                    if (!mem_ack_i) begin
                        w_state_next = BUSY_CORE;
                    end
                end else if (dma_req_i) begin
                    w_own_dma     = 1'b1;
                    w_streak_next = 4'd0;
                    if (!mem_ack_i) begin
                        w_state_next = BUSY_DMA;
                    end
                end
            end
            BUSY_CORE: begin
                w_own_core = 1'b1;
                if (mem_ack_i) begin
                    w_state_next = IDLE;
                end
            end
            BUSY_DMA: begin
                w_own_dma = 1'b1;
                if (mem_ack_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output routing. Everything is forced to zero while reset_n is low,
    // including the combinational pass-through paths.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        core_valid_o = 1'b0;
        dma_ack_o    = 1'b0;
        core_rdata_o = '0;
        dma_rdata_o  = '0;
        if (reset_n) begin
            core_rdata_o = mem_rdata_i;
            dma_rdata_o  = mem_rdata_i;
            if (w_own_core) begin
                mem_req_o    = 1'b1;
                mem_we_o     = core_write_i;
                mem_addr_o   = core_addr_i;
                mem_wdata_o  = core_wdata_i;
                core_valid_o = mem_ack_i;
            end else if (w_own_dma) begin
                mem_req_o   = 1'b1;
                mem_we_o    = dma_we_i;
                mem_addr_o  = dma_addr_i;
                mem_wdata_o = dma_wdata_i;
                dma_ack_o   = mem_ack_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter: directed scenarios plus a
//            randomized run against a transfer-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int MAXB = 4;
    localparam int AW   = 16;
    localparam int DW   = 16;

    logic          clk;
    logic          reset_n;
    logic          core_enable_i;
    logic          core_write_i;
    logic [AW-1:0] core_addr_i;
    logic [DW-1:0] core_wdata_i;
    logic [DW-1:0] core_rdata_o;
    logic          core_valid_o;
    logic          dma_req_i;
    logic          dma_we_i;
    logic [AW-1:0] dma_addr_i;
    logic [DW-1:0] dma_wdata_i;
    logic [DW-1:0] dma_rdata_o;
    logic          dma_ack_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.MAX_CORE_BURST(MAXB), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .core_enable_i(core_enable_i), .core_write_i(core_write_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_rdata_o(core_rdata_o), .core_valid_o(core_valid_o),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i),
        .dma_addr_i(dma_addr_i), .dma_wdata_i(dma_wdata_i),
        .dma_rdata_o(dma_rdata_o), .dma_ack_o(dma_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        core_enable_i = 0; core_write_i = 0; core_addr_i = '0; core_wdata_i = '0;
        dma_req_i = 0; dma_we_i = 0; dma_addr_i = '0; dma_wdata_i = '0;
        mem_ack_i = 0; mem_rdata_i = '0;
    endtask

    task automatic test_reset;
        logic [67:0] obs;
        core_enable_i = 1; dma_req_i = 1; core_addr_i = 16'h1111; dma_addr_i = 16'h2222;
        mem_ack_i = 1; mem_rdata_i = 16'hAAAA;
        #1;
        obs = {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, core_valid_o, dma_ack_o,
               core_rdata_o, dma_rdata_o};
        n_cmp++;
        if (obs !== 68'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        clear_inputs();
        tick();
        reset_n = 1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req_o, mem_addr_o} !== 17'h0) begin
            n_err++;
            $display("FAIL idle_after_reset: req/addr got %h expected 0", {mem_req_o, mem_addr_o});
        end
        tick();
    endtask

    task automatic test_core_read;
        core_enable_i = 1; core_write_i = 0; core_addr_i = 16'h0040;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin mem_ack_i = 1; mem_rdata_i = 16'hBEEF; end
            @(negedge clk);
            n_cmp++;
            if ({mem_req_o, mem_we_o, mem_addr_o, core_valid_o, dma_ack_o} !==
                {1'b1, 1'b0, 16'h0040, (c == 2), 1'b0}) begin
                n_err++;
                $display("FAIL core_read_c%0d: req=%b we=%b addr=%h valid=%b dack=%b expected 1 0 0040 %b 0",
                         c, mem_req_o, mem_we_o, mem_addr_o, core_valid_o, dma_ack_o, (c == 2));
            end
            if (c == 2) begin
                n_cmp++;
                if (core_rdata_o !== 16'hBEEF) begin
                    n_err++;
                    $display("FAIL core_read_rdata: got %h expected beef", core_rdata_o);
                end
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        n_cmp++;
        if ({mem_req_o, mem_addr_o} !== 17'h0) begin
            n_err++;
            $display("FAIL core_read_release: req/addr got %h expected 0", {mem_req_o, mem_addr_o});
        end
        tick();
    endtask

    task automatic test_back_to_back;
        core_enable_i = 1; core_addr_i = 16'h0010;
        dma_req_i = 1; dma_addr_i = 16'h0020;
        mem_ack_i = 1;
        for (int g = 0; g < 10; g++) begin
            logic exp_dma;
            exp_dma = ((g % 5) == 4);
            @(negedge clk);
            n_cmp++;
            if ({core_valid_o, dma_ack_o, mem_addr_o} !==
                {!exp_dma, exp_dma, exp_dma ? 16'h0020 : 16'h0010}) begin
                n_err++;
                $display("FAIL burst_grant%0d: cvalid=%b dack=%b addr=%h expected dack=%b",
                         g, core_valid_o, dma_ack_o, mem_addr_o, exp_dma);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_dma_inflight;
        dma_req_i = 1; dma_we_i = 1; dma_addr_i = 16'h0100; dma_wdata_i = 16'h1234;
        for (int c = 0; c < 4; c++) begin
            if (c >= 1) begin core_enable_i = 1; core_write_i = 0; core_addr_i = 16'h0200; end
            if (c == 3) mem_ack_i = 1;
            @(negedge clk);
            n_cmp++;
            if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, core_valid_o, dma_ack_o} !==
                {1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, (c == 3)}) begin
                n_err++;
                $display("FAIL dma_inflight_c%0d: req=%b we=%b addr=%h wd=%h cv=%b da=%b",
                         c, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, core_valid_o, dma_ack_o);
            end
            tick();
        end
        dma_req_i = 0; mem_rdata_i = 16'h5A5A;
        @(negedge clk);
        n_cmp++;
        if ({mem_addr_o, mem_we_o, core_valid_o, dma_ack_o, core_rdata_o} !==
            {16'h0200, 1'b0, 1'b1, 1'b0, 16'h5A5A}) begin
            n_err++;
            $display("FAIL core_after_dma: addr=%h we=%b cv=%b da=%b rd=%h expected 0200 0 1 0 5a5a",
                     mem_addr_o, mem_we_o, core_valid_o, dma_ack_o, core_rdata_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_core_write_same_cycle;
        core_enable_i = 1; core_write_i = 1; core_addr_i = 16'h0300; core_wdata_i = 16'hCAFE;
        mem_ack_i = 1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, core_valid_o} !==
            {1'b1, 1'b1, 16'h0300, 16'hCAFE, 1'b1}) begin
            n_err++;
            $display("FAIL core_write_1cyc: req=%b we=%b addr=%h wd=%h cv=%b expected 1 1 0300 cafe 1",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, core_valid_o);
        end
        tick();
        core_write_i = 0; core_addr_i = 16'h0304;
        @(negedge clk);
        n_cmp++;
        if ({mem_req_o, mem_we_o, mem_addr_o, core_valid_o} !== {1'b1, 1'b0, 16'h0304, 1'b1}) begin
            n_err++;
            $display("FAIL read_after_write: req=%b we=%b addr=%h cv=%b expected 1 0 0304 1",
                     mem_req_o, mem_we_o, mem_addr_o, core_valid_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_midtransfer;
        core_enable_i = 1; core_addr_i = 16'h0400;
        dma_req_i = 1; dma_addr_i = 16'h0500;
        // Three acked core grants then a fourth left pending: streak reaches the limit.
        mem_ack_i = 1;
        repeat (3) tick();
        mem_ack_i = 0;
        tick();
        #1 mem_ack_i = 1;
        #0.5;
        n_cmp++;
        if ({core_valid_o, mem_addr_o} !== {1'b1, 16'h0400}) begin
            n_err++;
            $display("FAIL busy_core_ack: cv=%b addr=%h expected 1 0400", core_valid_o, mem_addr_o);
        end
        #0.5 reset_n = 0;
        #1;
        n_cmp++;
        if ({mem_req_o, core_valid_o, dma_ack_o} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset_drop: req=%b cv=%b da=%b expected 000",
                     mem_req_o, core_valid_o, dma_ack_o);
        end
        tick();
        reset_n = 1;
        @(negedge clk);
        n_cmp++;
        if ({core_valid_o, dma_ack_o, mem_addr_o} !== {1'b1, 1'b0, 16'h0400}) begin
            n_err++;
            $display("FAIL first_grant_after_reset: cv=%b da=%b addr=%h expected 1 0 0400",
                     core_valid_o, dma_ack_o, mem_addr_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_dma_alone;
        dma_req_i = 1; mem_ack_i = 1;
        for (int i = 0; i < 3; i++) begin
            dma_addr_i = 16'h0600 + 16'(i);
            @(negedge clk);
            n_cmp++;
            if ({dma_ack_o, core_valid_o, mem_addr_o} !== {1'b1, 1'b0, 16'h0600 + 16'(i)}) begin
                n_err++;
                $display("FAIL dma_alone%0d: da=%b cv=%b addr=%h", i, dma_ack_o, core_valid_o, mem_addr_o);
            end
            tick();
        end
        // With the streak cleared, a full burst of core grants precedes the next DMA grant.
        core_enable_i = 1; core_addr_i = 16'h0700;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            n_cmp++;
            if ({core_valid_o, dma_ack_o} !== {(g != 4), (g == 4)}) begin
                n_err++;
                $display("FAIL streak_zero_grant%0d: cv=%b da=%b", g, core_valid_o, dma_ack_o);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_random;
        int          m_owner;   // 0 none, 1 core, 2 dma
        int          m_streak;
        int          core_since_dma;
        int          cur;
        logic [67:0] exp_v;
        logic [67:0] obs_v;
        logic        e_cv;
        logic        e_da;
        m_owner = 0; m_streak = 0; core_since_dma = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!core_enable_i && ($urandom_range(0, 1) == 1)) begin
                core_enable_i = 1; core_write_i = 1'($urandom);
                core_addr_i = 16'($urandom); core_wdata_i = 16'($urandom);
            end
            if (!dma_req_i && ($urandom_range(0, 2) == 0)) begin
                dma_req_i = 1; dma_we_i = 1'($urandom);
                dma_addr_i = 16'($urandom); dma_wdata_i = 16'($urandom);
            end
            cur = m_owner;
            if (cur == 0) begin
                if (core_enable_i && (!dma_req_i || m_streak < MAXB)) cur = 1;
                else if (dma_req_i) cur = 2;
            end
            mem_ack_i   = (cur != 0) && ($urandom_range(0, 2) != 0);
            mem_rdata_i = 16'($urandom);
            e_cv = mem_ack_i && (cur == 1);
            e_da = mem_ack_i && (cur == 2);
            if (cur == 1)
                exp_v = {1'b1, core_write_i, core_addr_i, core_wdata_i, e_cv, e_da, mem_rdata_i, mem_rdata_i};
            else if (cur == 2)
                exp_v = {1'b1, dma_we_i, dma_addr_i, dma_wdata_i, e_cv, e_da, mem_rdata_i, mem_rdata_i};
            else
                exp_v = {1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, mem_rdata_i, mem_rdata_i};
            @(negedge clk);
            obs_v = {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, core_valid_o, dma_ack_o,
                     core_rdata_o, dma_rdata_o};
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL random_cycle%0d: got %h expected %h", n, obs_v, exp_v);
            end
            // DMA progress: a transfer already in flight when DMA raised its
            // request may add one completion to the bounded burst.
            if (core_valid_o && dma_req_i) core_since_dma++;
            if (dma_ack_o) begin
                n_cmp++;
                if (core_since_dma > MAXB + 1) begin
                    n_err++;
                    $display("FAIL dma_starvation: %0d core completions while waiting, limit %0d",
                             core_since_dma, MAXB + 1);
                end
                core_since_dma = 0;
            end
            if (m_owner == 0 && cur != 0)
                m_streak = (cur == 1 && dma_req_i) ? ((m_streak + 1 > MAXB) ? MAXB : m_streak + 1) : 0;
            if (cur != 0) m_owner = mem_ack_i ? 0 : cur;
            tick();
            if (e_cv) core_enable_i = 0;
            if (e_da) dma_req_i = 0;
        end
        clear_inputs();
    endtask

    initial begin
        reset_n = 0;
        clear_inputs();
        #2;
        test_reset();
        test_core_read();
        test_back_to_back();
        test_dma_inflight();
        test_core_write_same_cycle();
        test_reset_midtransfer();
        test_dma_alone();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares one single-port data memory between the vcore data port (dmem_* handshake) and a secondary DMA/debug requester.
Grants whole transfers. Core has priority; a bounded-streak counter guarantees DMA progress.
Sits between the vcore data interface and the memory/bus wrapper, and adds zero cycles when uncontended.

Parameters:
MAX_CORE_BURST, 4, consecutive core grants allowed while DMA waits before DMA is forced (legal 1..15)
AW, 16, address width
DW, 16, data width

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
core_enable_i  in  1  core transfer request (level; held until core_valid_o)
core_write_i  in  1  1=write, 0=read
core_addr_i  in  AW  core address
core_wdata_i  in  DW  core write data
core_rdata_o  out  DW  read data, meaningful with core_valid_o
core_valid_o  out  1  core transfer complete this cycle
dma_req_i  in  1  DMA request (level; held until dma_ack_o)
dma_we_i  in  1  1=write
dma_addr_i  in  AW  DMA address
dma_wdata_i  in  DW  DMA write data
dma_rdata_o  out  DW  read data, meaningful with dma_ack_o
dma_ack_o  out  1  DMA transfer complete this cycle
mem_req_o  out  1  memory request; held with stable we/addr/wdata until mem_ack_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  AW  memory address
mem_wdata_o  out  DW  memory write data
mem_ack_i  in  1  memory completes the transfer; mem_rdata_i valid in the same cycle
mem_rdata_i  in  DW  memory read data

Behaviour:
- States: IDLE, BUSY_CORE, BUSY_DMA (registered); plus 4-bit streak counter.
- IDLE: combinational arbitration in the same cycle, so no added latency.
  - Core only -> core granted.
  - DMA only -> DMA granted.
  - Both, streak < MAX_CORE_BURST -> core granted.
  - Both, streak == MAX_CORE_BURST -> DMA granted.
  - Granted requester's we/addr/wdata routed to mem_*; mem_req_o=1.
  - mem_ack_i in the same cycle -> transfer completes, stay IDLE.
  - Otherwise -> BUSY_<owner>.
- BUSY_x: mem_* driven from owner x only; the other requester is ignored. On mem_ack_i -> IDLE, so the next arbitration happens the following cycle. Back-to-back transfers therefore run at one per ack.
- Completion:
  - core_valid_o = mem_ack_i && owner==core (combinational).
  - dma_ack_o = mem_ack_i && owner==DMA (combinational).
  - core_rdata_o = dma_rdata_o = mem_rdata_i, passed through combinationally. The core consumes read data in the valid cycle.
- Streak counter, updated at each grant:
  - Core granted while dma_req_i=1 -> streak+1, saturating at MAX_CORE_BURST.
  - DMA granted, or dma_req_i=0 at the grant -> streak=0.
- No owner and no request: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Protocol violation (owner drops its request before ack): mem_req_o and the latched owner stay asserted until mem_ack_i, because the memory side must not be withdrawn. The completing ack is still pulsed to the owner; the requester ignores it. Owner we/addr/wdata are sampled live, so the requester must hold them stable.
- A core write with mem_ack_i on the first cycle must complete in 1 cycle. This matches the vcore MEM_WRITE state seeing dmem_valid_i immediately.
- Reset (async, any time including mid-transfer): state=IDLE, streak=0. All outputs 0 while reset_n=0. An in-flight transfer is abandoned; the memory wrapper is reset by the same reset_n.

Test Plan:
- Core read only, addr 0x0040, mem_ack_i 2 cycles after request, mem_rdata_i=0xBEEF -> mem_req_o high 3 cycles; core_valid_o one pulse with core_rdata_o=0xBEEF; dma_ack_o never asserted.
- Core and DMA both request continuously, MAX_CORE_BURST=4, ack every cycle -> grant sequence C,C,C,C,D,C,C,C,C,D; every DMA transfer served within 5 grants.
- DMA write 0x1234 to 0x0100 in flight (BUSY_DMA, ack delayed 3 cycles); core requests mid-transfer -> mem_addr_o stays 0x0100 until ack; core granted the cycle after the DMA ack.
- Core write with mem_ack_i in the same cycle as request -> core_valid_o in that cycle; state remains IDLE; next core read granted the following cycle.
- reset_n pulsed low during BUSY_CORE -> mem_req_o, core_valid_o and dma_ack_o drop to 0 asynchronously; after release, streak=0 and the first grant goes to the core when both request.
- DMA requests alone 3 times with core idle -> three DMA grants with zero arbitration delay; streak stays 0.
